fir_output_stage: RTL
=====================

Name: fir_output_stage

Overview:
- Downstream consumer of the FIR filter's 32-bit accumulator output.
- Per sample:
  - rounds and arithmetically shifts the full-precision result;
  - saturates it to a 16-bit sample;
  - optionally decimates;
  - buffers results in a small FIFO behind a valid/ready handshake for the DAC/stream sink.
- Upstream has no backpressure, so overflow is detected, counted and flagged here.

Parameters:
- IN_W, 32, input sample width (signed, two's complement)
- OUT_W, 16, output sample width (signed)
- SHIFT, 15, right-shift applied after rounding; legal range 1..IN_W-OUT_W+1
- DECIM, 1, keep one of every DECIM valid inputs; legal range 1..16
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  data_in is a new sample this cycle
- data_in  in  IN_W  signed FIR result
- clr_flags  in  1  synchronous pulse; clears sat_flag, ovf_flag, drop_count
- out_valid  out  1  FIFO head valid
- out_ready  in  1  sink accepts head this cycle
- data_out  out  OUT_W  FIFO head sample, signed
- sat_flag  out  1  sticky: a kept sample was clipped
- ovf_flag  out  1  sticky: a sample was dropped because the FIFO was full
- drop_count  out  8  dropped-sample count, saturates at 255

Behaviour:
- Reset (reset=0, asynchronous), all of the following cleared:
  - out_valid=0, data_out=0, sat_flag=0, ovf_flag=0, drop_count=0;
  - FIFO empty, pipeline valids 0, decimation phase 0.
- Decimation:
  - Phase counter 0..DECIM-1 advances on every in_valid and wraps to 0.
  - A sample is kept only when phase==0 at its arrival; the first valid after reset is kept.
  - DECIM=1 keeps every sample.
- Stage 1 (edge E1 after acceptance at E0): r = (sign-extended data_in, IN_W+1 bits) + 2^(SHIFT-1), then arithmetic shift right by SHIFT.
  - This is round-half-up: -0.5 LSB rounds to 0.
  - The IN_W+1 width prevents overflow of the add.
- Stage 2 (edge E2):
  - If r exceeds [-2^(OUT_W-1), 2^(OUT_W-1)-1], clip to the nearest bound and set sat_flag.
  - Write the result to the FIFO.
- Latency: a sample kept at E0 is visible on data_out with out_valid=1 in the cycle after E2, i.e. 2 cycles, when the FIFO is empty. Full throughput of one sample per cycle.
- FIFO:
  - data_out is the head entry, driven from storage, not from the pipeline.
  - A pop occurs on any edge with out_valid & out_ready.
  - out_valid=1 whenever count>0.
  - data_out holds its value while out_valid=1 and out_ready=0.
  - When empty, data_out holds the last popped value.
- Boundary conditions:
  - Full, with a write and a pop on the same edge: both occur, no drop, count unchanged.
  - Full, with a write and no pop: the new sample is discarded, the FIFO is untouched, ovf_flag is set, drop_count increments (holds at 255).
  - Empty, with a write: out_valid rises the next cycle. There is no write-to-read bypass in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Flags:
  - clr_flags clears all three flag outputs on the next edge.
  - If a set event occurs on the same edge as clr_flags, the set wins: the flag reads 1 and drop_count reads 1.
- Mid-stream reset: everything is lost immediately (asynchronous). There is no partial output after release.
- Release of reset is synchronised by the integrator. No samples are accepted while reset=0.

Optional Feature:
- Macro FIR_OUT_SAT_EN.
- Defined: saturation exactly as described in Behaviour, and sat_flag is live.
- Undefined: stage 2 truncates r to its low OUT_W bits (wrap-around), and sat_flag is tied to 0.
- Undefined removes the compare logic; every other behaviour is identical.

Test Plan:
- Rounding with SHIFT=15, DECIM=1 and out_ready held 1:
  - data_in 0x00004000 -> 0x0001
  - data_in 0x00003FFF -> 0x0000
  - data_in 0xFFFFC000 -> 0x0000
  - each appears 2 cycles after input; sat_flag stays 0.
- Saturation with FIR_OUT_SAT_EN defined:
  - 0x40000000 -> 0x7FFF, sat_flag=1;
  - 0x80000000 -> 0x8000;
  - a clr_flags pulse clears sat_flag.
- Same saturation inputs with FIR_OUT_SAT_EN undefined: 0x40000000 -> 0x8000, sat_flag=0.
- Decimation with DECIM=4 and a ramp of data_in k·2^15 for k=0..11 on consecutive cycles -> outputs 0, 4, 8 only, in order.
- Overflow with FIFO_DEPTH=4, out_ready=0 and six kept samples 1..6:
  - out_valid=1, FIFO holds 1..4, drop_count=2, ovf_flag=1;
  - then out_ready=1 pops 1, 2, 3, 4 in order, after which out_valid=0.
- Full FIFO with a simultaneous write and pop -> no drop, count stays 4.
- reset pulled low mid-burst -> out_valid=0 and all flags 0 within the same cycle.

Source files
------------

// File: rtl/fir_output_stage.sv
// fir_output_stage: output stage behind the FIR accumulator.
//   E0: decimation decision, kept sample captured
//   E1: round-half-up and arithmetic shift by SHIFT
//   E2: saturate (or wrap) to OUT_W and write into the output FIFO
// The FIFO head drives data_out directly from storage.
//
// Optional feature macro: FIR_OUT_SAT_EN
//   defined   -> stage 2 clips to the OUT_W signed range and sat_flag is live
//   undefined -> stage 2 keeps the low OUT_W bits (wrap) and sat_flag is 0
//
// Handshake: a FIFO entry transfers on every rising edge where
// out_valid && out_ready. out_valid is high exactly while the FIFO holds
// at least one entry, and data_out stays stable while out_valid is high
// and out_ready is low. The upstream side has no backpressure: a write
// that arrives while the FIFO is full and not popping is dropped and
// reported through ovf_flag and drop_count.
module fir_output_stage #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  data_in,
  input  logic             clr_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             sat_flag,
  output logic             ovf_flag,
  output logic [7:0]       drop_count
);

  localparam int PH_W = 5;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
`ifdef FIR_OUT_SAT_EN
  localparam int R_W  = IN_W + 1;
`else
  localparam int R_W  = OUT_W;
`endif

  // Rounding constant 2^(SHIFT-1) at the widened stage-1 width.
  localparam logic [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  // ---------------- stage 0: decimation ----------------
  logic [PH_W-1:0] phase;
  logic            s0_valid;
  logic [IN_W-1:0] s0_data;
  logic            keep;

  assign keep = in_valid && (phase == '0);

  // Phase advances on every valid input; only phase 0 samples are kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      s0_valid <= 1'b0;
      s0_data  <= '0;
    end else begin
      s0_valid <= keep;
      if (keep) begin
        s0_data <= data_in;
      end
      if (in_valid) begin
        if (phase == PH_W'(DECIM - 1)) begin
          phase <= '0;
        end else begin
          phase <= phase + 1'b1;
        end
      end
    end
  end

  // ---------------- stage 1: round and shift ----------------
  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] sum;

  // Sign-extend by one bit so adding the rounding constant cannot overflow.
  always_comb begin
    ext = $signed({s0_data[IN_W-1], s0_data});
    sum = ext + $signed(RND);
  end

  logic                  s1_valid;
  logic signed [R_W-1:0] s1_r;

  // Register the shifted result; in wrap mode only the low OUT_W bits matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_r <= R_W'(sum >>> SHIFT);
      end
    end
  end

  // ---------------- stage 2: saturate / wrap ----------------
  logic [OUT_W-1:0] sample;

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [IN_W:0] MAX_V =
    $signed({{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

  logic clip;

  // Clip to the nearest OUT_W signed bound when out of range.
  always_comb begin
    sample = s1_r[OUT_W-1:0];
    clip   = 1'b0;
    if (s1_r > MAX_V) begin
      sample = {1'b0, {(OUT_W - 1){1'b1}}};
      clip   = 1'b1;
    end else if (s1_r < MIN_V) begin
      sample = {1'b1, {(OUT_W - 1){1'b0}}};
      clip   = 1'b1;
    end
  end

  // Sticky saturation flag; a set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
    end else if (s1_valid && clip) begin
      sat_flag <= 1'b1;
    end else if (clr_flags) begin
      sat_flag <= 1'b0;
    end
  end
`else
  // Wrap-around: keep the low OUT_W bits of the rounded result.
  always_comb begin
    sample = s1_r;
  end

  assign sat_flag = 1'b0;
`endif

  // ---------------- output FIFO ----------------
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [AW-1:0]    head_idx;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = s1_valid && (!full || pop);
  assign drop      = s1_valid && full && !pop;

  // When empty, point at the slot of the last popped entry so it is held.
  always_comb begin
    head_idx = rd_ptr;
    if (count == '0) begin
      head_idx = rd_ptr - 1'b1;
    end
  end

  assign data_out = mem[head_idx];

  // Storage, pointers and occupancy; pointers wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sample;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_flag   <= 1'b0;
      drop_count <= '0;
    end else if (clr_flags) begin
      ovf_flag   <= drop;
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
